// File: rtl/lnrv_exu_wbck_arb.sv
`default_nettype none
// lnrv_exu_wbck_arb: NUM_SRC-way GPR write-back arbiter feeding a single registered output slot.
// Define LNRV_WBCK_RR_EN for round-robin arbitration; otherwise fixed priority (source 0 highest).
module lnrv_exu_wbck_arb #(
  parameter int NUM_SRC = 5,
  parameter int XLEN    = 32,
  parameter int IDX_W   = 5,
  parameter int SRC_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_wbck_vld,
  output logic [NUM_SRC-1:0]       src_wbck_rdy,
  input  logic [NUM_SRC*IDX_W-1:0] src_wbck_idx,
  input  logic [NUM_SRC*XLEN-1:0]  src_wbck_wdata,
  output logic                     gpr_wbck_vld,
  input  logic                     gpr_wbck_rdy,
  output logic [IDX_W-1:0]         gpr_wbck_idx,
  output logic [XLEN-1:0]          gpr_wbck_wdata,
  output logic [SRC_W-1:0]         gpr_wbck_src
);

  logic               load_en;
  logic               accept;
  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   win_id;
  logic [IDX_W-1:0]   win_idx;
  logic [XLEN-1:0]    win_wdata;

  logic               gpr_vld_q;
  logic [IDX_W-1:0]   gpr_idx_q;
  logic [XLEN-1:0]    gpr_wdata_q;
  logic [SRC_W-1:0]   gpr_src_q;

  assign load_en = ~gpr_vld_q | gpr_wbck_rdy;
  // Accept is masked during reset so no source believes it was consumed.
  assign accept       = (|src_wbck_vld) & load_en & rst_n;
  assign src_wbck_rdy = grant & {NUM_SRC{load_en & rst_n}};

`ifdef LNRV_WBCK_RR_EN
  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] ptr_d;
  logic             found;
  int               pos;

  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      if (!found && src_wbck_vld[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        win_id     = SRC_W'(pos);
      end
    end
  end

  assign ptr_d = (win_id == SRC_W'(NUM_SRC - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant  = '0;
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_wbck_vld[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        win_id   = SRC_W'(i);
      end
    end
  end
`endif

  always_comb begin
    win_idx   = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_idx   = src_wbck_idx[i*IDX_W +: IDX_W];
        win_wdata = src_wbck_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are consumed but leave the slot empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpr_vld_q   <= 1'b0;
      gpr_idx_q   <= '0;
      gpr_wdata_q <= '0;
      gpr_src_q   <= '0;
    end else if (load_en) begin
      if (accept && (win_idx != '0)) begin
        gpr_vld_q   <= 1'b1;
        gpr_idx_q   <= win_idx;
        gpr_wdata_q <= win_wdata;
        gpr_src_q   <= win_id;
      end else begin
        gpr_vld_q   <= 1'b0;
      end
    end
  end

  assign gpr_wbck_vld   = gpr_vld_q;
  assign gpr_wbck_idx   = gpr_idx_q;
  assign gpr_wbck_wdata = gpr_wdata_q;
  assign gpr_wbck_src   = gpr_src_q;

endmodule
`default_nettype wire

// File: tb/tb_lnrv_exu_wbck_arb.sv
`default_nettype none
// tb_lnrv_exu_wbck_arb: directed self-checking bench for the write-back arbiter.
module tb_lnrv_exu_wbck_arb;

  logic         clk;
  logic         rst_n;
  logic [4:0]   src_vld;
  logic [4:0]   src_rdy;
  logic [24:0]  src_idx;
  logic [159:0] src_wdata;
  logic         gpr_vld;
  logic         gpr_rdy;
  logic [4:0]   gpr_idx;
  logic [31:0]  gpr_wdata;
  logic [2:0]   gpr_src;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  lnrv_exu_wbck_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_wbck_vld   (src_vld),
    .src_wbck_rdy   (src_rdy),
    .src_wbck_idx   (src_idx),
    .src_wbck_wdata (src_wdata),
    .gpr_wbck_vld   (gpr_vld),
    .gpr_wbck_rdy   (gpr_rdy),
    .gpr_wbck_idx   (gpr_idx),
    .gpr_wbck_wdata (gpr_wdata),
    .gpr_wbck_src   (gpr_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] id, input logic [31:0] d);
    src_vld[i]            = v;
    src_idx[i*5 +: 5]     = id;
    src_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    int exp_win;
    rst_n     = 1'b0;
    gpr_rdy   = 1'b1;
    src_vld   = '0;
    src_idx   = '0;
    src_wdata = '0;
    for (int i = 0; i < 5; i++) set_src(i, 1'b1, 5'(i + 1), 32'h100 + i);

    // Reset with every source requesting
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_vld",   gpr_vld,   0);
      chk("rst_idx",   gpr_idx,   0);
      chk("rst_wdata", gpr_wdata, 0);
      chk("rst_src",   gpr_src,   0);
      chk("rst_rdy",   src_rdy,   0);
    end
    src_vld = '0;
    rst_n   = 1'b1;
    step();
    chk("idle_vld", gpr_vld, 0);

    // Single request from source 2
    set_src(2, 1'b1, 5'd7, 32'hDEAD_BEEF);
    #1 chk("single_rdy", src_rdy, 5'b00100);
    step();
    src_vld = '0;
    chk("single_vld",   gpr_vld,   1);
    chk("single_idx",   gpr_idx,   7);
    chk("single_wdata", gpr_wdata, 32'hDEAD_BEEF);
    chk("single_src",   gpr_src,   2);

    // Backpressure while source 1 waits
    gpr_rdy = 1'b0;
    set_src(1, 1'b1, 5'd9, 32'h1111_2222);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_rdy", src_rdy, 0);
      step();
      chk("bp_vld",   gpr_vld,   1);
      chk("bp_idx",   gpr_idx,   7);
      chk("bp_wdata", gpr_wdata, 32'hDEAD_BEEF);
      chk("bp_src",   gpr_src,   2);
    end
    gpr_rdy = 1'b1;
    #1 chk("bp_release_rdy", src_rdy, 5'b00010);
    step();
    src_vld = '0;
    chk("bp_out_vld",   gpr_vld,   1);
    chk("bp_out_idx",   gpr_idx,   9);
    chk("bp_out_wdata", gpr_wdata, 32'h1111_2222);
    chk("bp_out_src",   gpr_src,   1);
    step();
    chk("drain_vld",  gpr_vld, 0);
    chk("drain_hold", gpr_idx, 9);

    // Contention from a freshly reset pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) set_src(i, 1'b1, 5'(i + 1), 32'h100 + i);
    for (int c = 0; c < 6; c++) begin
`ifdef LNRV_WBCK_RR_EN
      exp_win = c % 5;
`else
      exp_win = 0;
`endif
      #1 chk("cont_rdy", src_rdy, 5'(1 << exp_win));
      step();
      chk("cont_vld", gpr_vld,   1);
      chk("cont_src", gpr_src,   exp_win);
      chk("cont_idx", gpr_idx,   exp_win + 1);
      chk("cont_dat", gpr_wdata, 32'h100 + exp_win);
    end
    src_vld = '0;
    step();
    chk("cont_drain", gpr_vld, 0);

    // x0 write is consumed but never presented
    set_src(3, 1'b1, 5'd0, 32'hBAD0_0000);
    #1 chk("x0_rdy", src_rdy, 5'b01000);
    step();
    src_vld = '0;
    chk("x0_vld", gpr_vld, 0);

    // Back-to-back stream from source 4
    for (int k = 1; k <= 8; k++) begin
      set_src(4, 1'b1, 5'(k), 32'hA000 + k);
      #1 chk("b2b_rdy", src_rdy, 5'b10000);
      step();
      chk("b2b_vld", gpr_vld,   1);
      chk("b2b_idx", gpr_idx,   k);
      chk("b2b_dat", gpr_wdata, 32'hA000 + k);
      chk("b2b_src", gpr_src,   4);
    end
    src_vld = '0;
    step();
    chk("b2b_end", gpr_vld, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
